// File: rtl/ifm_line_scheduler.sv
// ifm_line_scheduler: issues one loader run per IFM row into a 2-bank ping-pong line buffer and hands filled banks to the consumer in order
module ifm_line_scheduler #(
  parameter int DIM_W  = 8,
  parameter int BANK_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_ifm_w,
  input  logic [DIM_W-1:0]  cfg_ifm_h,
  input  logic [DIM_W-1:0]  cfg_ich,
  output logic              busy,
  output logic              done,
  output logic              ld_start,
  output logic [DIM_W-1:0]  ld_ifm_w,
  output logic [DIM_W-1:0]  ld_ich,
  output logic [DIM_W-1:0]  ld_line_idx,
  output logic [BANK_W-1:0] ld_bank,
  input  logic              ld_done,
  output logic              out_valid,
  output logic [BANK_W-1:0] out_bank,
  output logic [DIM_W-1:0]  out_line_idx,
  output logic              out_last,
  input  logic              out_release
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LD, WAIT_BUF, DRAIN, DONE} state_t;
  state_t                   state_q, state_d;
  logic [DIM_W:0]           line_cnt_q, line_cnt_d;
  logic [DIM_W-1:0]         ifm_w_q, ifm_w_d, ifm_h_q, ifm_h_d, ich_q, ich_d;
  logic [1:0]               full_q, full_d;
  logic [1:0][DIM_W-1:0]    line_of_q, line_of_d;
  logic [BANK_W-1:0]        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic                     ld_start_q, ld_start_d, busy_q, busy_d, done_q, done_d;
  logic                     rel;
  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    ifm_w_d    = ifm_w_q;
    ifm_h_d    = ifm_h_q;
    ich_d      = ich_q;
    full_d     = full_q;
    line_of_d  = line_of_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rel        = out_release && full_q[rd_bank_q];
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    case (state_q)
      IDLE: if (start) begin
        ifm_w_d    = cfg_ifm_w;
        ifm_h_d    = cfg_ifm_h;
        ich_d      = cfg_ich;
        line_cnt_d = '0;
        state_d    = cfg_ifm_h == '0 ? DRAIN : ISSUE;
      end
      ISSUE: state_d = WAIT_LD;
      WAIT_LD: if (ld_done) begin
        full_d[wr_bank_q]    = 1'b1;
        line_of_d[wr_bank_q] = line_cnt_q[DIM_W-1:0];
        wr_bank_d            = ~wr_bank_q;
        line_cnt_d           = line_cnt_q + (DIM_W+1)'(1);
        // a release in this same cycle may already have freed the next bank
        state_d = line_cnt_d == {1'b0, ifm_h_q} ? DRAIN : full_d[wr_bank_d] ? WAIT_BUF : ISSUE;
      end
      WAIT_BUF: state_d = full_q[wr_bank_q] ? WAIT_BUF : ISSUE;
      DRAIN:    state_d = full_q == 2'b00 ? DONE : DRAIN;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    ld_start_d = state_d == ISSUE;
    done_d     = state_d == DONE;
    busy_d     = !(state_d == IDLE || state_d == DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_cnt_q <= '0;
      ifm_w_q    <= '0;
      ifm_h_q    <= '0;
      ich_q      <= '0;
      full_q     <= '0;
      line_of_q  <= '0;
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      ld_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      ifm_w_q    <= ifm_w_d;
      ifm_h_q    <= ifm_h_d;
      ich_q      <= ich_d;
      full_q     <= full_d;
      line_of_q  <= line_of_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      ld_start_q <= ld_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign busy         = busy_q;
  assign done         = done_q;
  assign ld_start     = ld_start_q;
  assign ld_ifm_w     = ifm_w_q;
  assign ld_ich       = ich_q;
  assign ld_line_idx  = line_cnt_q[DIM_W-1:0];
  assign ld_bank      = wr_bank_q;
  assign out_valid    = full_q[rd_bank_q];
  assign out_bank     = rd_bank_q;
  assign out_line_idx = line_of_q[rd_bank_q];
  assign out_last     = out_valid && line_of_q[rd_bank_q] == ifm_h_q - DIM_W'(1);
endmodule

// File: tb/tb_ifm_line_scheduler.sv
// tb_ifm_line_scheduler: randomized loader/consumer stimulus checked against a queue model of the ping-pong buffer
module tb_ifm_line_scheduler;
  logic       clk = 1'b0;
  logic       rst, start, ld_done, out_release;
  logic [7:0] cfg_ifm_w, cfg_ifm_h, cfg_ich;
  logic       busy, done, ld_start, out_valid, out_last;
  logic [7:0] ld_ifm_w, ld_ich, ld_line_idx, out_line_idx;
  logic       ld_bank, out_bank;
  int         total = 0;
  int         bad = 0;
  int         exp_bank = 0;
  int         q_line[$];
  int         q_bank[$];
  ifm_line_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .cfg_ifm_w(cfg_ifm_w), .cfg_ifm_h(cfg_ifm_h),
    .cfg_ich(cfg_ich), .busy(busy), .done(done), .ld_start(ld_start), .ld_ifm_w(ld_ifm_w),
    .ld_ich(ld_ich), .ld_line_idx(ld_line_idx), .ld_bank(ld_bank), .ld_done(ld_done),
    .out_valid(out_valid), .out_bank(out_bank), .out_line_idx(out_line_idx),
    .out_last(out_last), .out_release(out_release)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ld_start"}, ld_start, 0);
    chk({tag, "_ld_w"}, ld_ifm_w, 0);
    chk({tag, "_ld_ich"}, ld_ich, 0);
    chk({tag, "_ld_line"}, ld_line_idx, 0);
    chk({tag, "_ld_bank"}, ld_bank, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_bank"}, out_bank, 0);
    chk({tag, "_out_line"}, out_line_idx, 0);
    chk({tag, "_out_last"}, out_last, 0);
  endtask
  // h lines, release probability rel_pct, no releases before cycle hold,
  // abort_line>=0 resets while that line's load is in flight
  task automatic run(input int h, input int rel_pct, input int hold, input int abort_line);
    int  w = $urandom_range(1, 255);
    int  c = $urandom_range(1, 255);
    int  issued = 0, released = 0, pending = 0, timer = 0, cyc = 0;
    bit  fin = 0, aborted = 0, vld;
    @(negedge clk);
    start = 1; cfg_ifm_w = 8'(w); cfg_ifm_h = 8'(h); cfg_ich = 8'(c);
    @(negedge clk);
    start = 0; cfg_ifm_w = 8'($urandom); cfg_ifm_h = 8'($urandom); cfg_ich = 8'($urandom);
    while (!fin && !aborted && cyc < 20000) begin
      cyc++;
      vld = q_line.size() > 0;
      chk("out_valid", out_valid, vld);
      if (vld) begin
        chk("out_bank", out_bank, q_bank[0]);
        chk("out_line", out_line_idx, q_line[0]);
        chk("out_last", out_last, q_line[0] == h - 1);
      end
      if (ld_start) begin
        if (issued == 0) chk("ld_latency", cyc, 1);
        chk("ld_overlap", pending, 0);
        chk("ld_room", q_line.size() < 2, 1);
        chk("ld_line", ld_line_idx, issued);
        chk("ld_bank", ld_bank, exp_bank);
        chk("ld_w", ld_ifm_w, w);
        chk("ld_ich", ld_ich, c);
        pending = 1;
        timer = $urandom_range(1, 4);
        issued++;
      end else if (pending) begin
        chk("ld_hold_line", ld_line_idx, issued - 1);
        chk("ld_hold_bank", ld_bank, exp_bank);
      end
      if (done) begin
        chk("done_busy", busy, 0);
        chk("done_released", released, h);
        chk("done_loads", issued, h);
        if (h == 0) chk("done_latency", cyc, 2);
        fin = 1;
      end else begin
        chk("busy", busy, 1);
        if (hold > 0 && cyc == hold && h >= 3) chk("hold_loads", issued, 2);
        if (abort_line >= 0 && pending && issued == abort_line + 1) aborted = 1;
      end
      if (!fin && !aborted) begin
        ld_done = 0;
        if (pending) begin
          if (timer == 0) ld_done = 1;
          else timer--;
        end else ld_done = $urandom_range(0, 9) == 0;
        out_release = (cyc >= hold && $urandom_range(0, 99) < rel_pct) || (!vld && $urandom_range(0, 4) == 0);
        start = $urandom_range(0, 15) == 0;
        cfg_ifm_h = 8'($urandom);
        if (out_release && vld) begin
          void'(q_line.pop_front());
          void'(q_bank.pop_front());
          released++;
        end
        if (ld_done && pending) begin
          q_line.push_back(issued - 1);
          q_bank.push_back(exp_bank);
          exp_bank ^= 1;
          pending = 0;
        end
        @(negedge clk);
      end
    end
    start = 0; ld_done = 0; out_release = 0;
    if (aborted) begin
      rst = 1;
      @(negedge clk);
      chk_zero("abort");
      rst = 0;
      q_line.delete();
      q_bank.delete();
      exp_bank = 0;
    end else if (!fin) chk("timeout", 0, 1);
    else begin
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_ld_start", ld_start, 0);
      chk("post_busy", busy, 0);
    end
  endtask
  initial begin
    rst = 1; start = 0; ld_done = 0; out_release = 0;
    cfg_ifm_w = 0; cfg_ifm_h = 0; cfg_ich = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    run(4, 50, 0, -1);
    run(5, 60, 40, -1);
    run(6, 100, 0, -1);
    run(0, 50, 0, -1);
    run(6, 50, 0, 3);
    run(2, 50, 0, -1);
    for (int i = 0; i < 8; i++) run($urandom_range(1, 12), $urandom_range(20, 90), 0, -1);
    run(255, 80, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
